// File: rtl/avalon_arb_pkg.sv
// avalon_arb_pkg: shared FSM state and host id types for the 2-to-1 Avalon-MM arbiter
package avalon_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, WR_BURST, RD_WAIT} arb_state_t;
  typedef logic host_id_t;
  localparam host_id_t HOST0 = 1'b0;
  localparam host_id_t HOST1 = 1'b1;
endpackage

// File: rtl/avalon_if.sv
// avalon_if: Avalon-MM burst-capable bus with host and agent views
interface avalon_if #(parameter int ADDR_W = 32, parameter int BURSTCOUNT_W = 4);
  logic [ADDR_W-1:0] address;
  logic read;
  logic write;
  logic [31:0] writedata;
  logic [3:0] byteenable;
  logic [BURSTCOUNT_W-1:0] burstcount;
  logic [31:0] readdata;
  logic readdatavalid;
  logic waitrequest;
  modport host (output address, read, write, writedata, byteenable, burstcount,
                input readdata, readdatavalid, waitrequest);
  modport agent (input address, read, write, writedata, byteenable, burstcount,
                 output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: picks the next owner from two requests; ARB_FIXED_PRIO_EN selects fixed h0 priority
module arb_rr_pick
  import avalon_arb_pkg::*;
(
  input  logic [1:0] req,
  input  host_id_t   last_owner,
  output host_id_t   pick
);
`ifdef ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{last_owner, req[1]};
  assign pick = req[0] ? HOST0 : HOST1;
`else
  assign pick = (req == 2'b11) ? ~last_owner : (req[1] ? HOST1 : HOST0);
`endif
endmodule

// File: rtl/avalon_arbiter_2to1.sv
// avalon_arbiter_2to1: grants whole Avalon-MM bursts from h0/h1 to one agent; ARB_FIXED_PRIO_EN = fixed h0 priority
module avalon_arbiter_2to1
  import avalon_arb_pkg::*;
#(
  parameter int BURSTCOUNT_W = 4
) (
  input logic     clk,
  input logic     reset,
  avalon_if.agent h0,
  avalon_if.agent h1,
  avalon_if.host  m
);
  arb_state_t state;
  host_id_t owner, last_owner, pick;
  logic [BURSTCOUNT_W-1:0] beat_cnt, burst_reg, o_bc, bc1, beat_nxt;
  logic act, rdw, sel1, o_read, o_write;
  arb_rr_pick u_pick (.req({h1.read | h1.write, h0.read | h0.write}), .last_owner(last_owner), .pick(pick));
  always_comb begin
    sel1 = owner == HOST1;
    act = reset && (state == GRANT || state == WR_BURST);
    rdw = reset && state == RD_WAIT;
    o_read = sel1 ? h1.read : h0.read;
    o_write = sel1 ? h1.write : h0.write;
    o_bc = sel1 ? h1.burstcount : h0.burstcount;
    bc1 = (o_bc == '0) ? BURSTCOUNT_W'(1) : o_bc;
    beat_nxt = beat_cnt + 1'b1;
  end
  // read wins over a simultaneous write; commands only pass while a grant is active
  assign m.read = act && state == GRANT && o_read;
  assign m.write = act && o_write && !(state == GRANT && o_read);
  assign m.address = act ? (sel1 ? h1.address : h0.address) : '0;
  assign m.writedata = act ? (sel1 ? h1.writedata : h0.writedata) : '0;
  assign m.byteenable = act ? (sel1 ? h1.byteenable : h0.byteenable) : '0;
  assign m.burstcount = act ? o_bc : BURSTCOUNT_W'(1);
  assign h0.waitrequest = !(act && !sel1) || m.waitrequest;
  assign h1.waitrequest = !(act && sel1) || m.waitrequest;
  assign h0.readdatavalid = rdw && !sel1 && m.readdatavalid;
  assign h1.readdatavalid = rdw && sel1 && m.readdatavalid;
  assign h0.readdata = (rdw && !sel1) ? m.readdata : '0;
  assign h1.readdata = (rdw && sel1) ? m.readdata : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      owner <= HOST0;
      last_owner <= HOST1;
      beat_cnt <= '0;
      burst_reg <= BURSTCOUNT_W'(1);
    end else begin
      case (state)
        IDLE: if (h0.read || h0.write || h1.read || h1.write) begin
          owner <= pick;
          state <= GRANT;
        end
        GRANT: if (!(o_read || o_write)) state <= IDLE;
        else if (!m.waitrequest) begin
          burst_reg <= bc1;
          beat_cnt <= o_read ? '0 : BURSTCOUNT_W'(1);
          state <= o_read ? RD_WAIT : ((bc1 == BURSTCOUNT_W'(1)) ? IDLE : WR_BURST);
          if (!o_read && bc1 == BURSTCOUNT_W'(1)) last_owner <= owner;
        end
        WR_BURST: if (o_write && !m.waitrequest) begin
          beat_cnt <= beat_nxt;
          if (beat_nxt == burst_reg) begin
            state <= IDLE;
            last_owner <= owner;
          end
        end
        RD_WAIT: if (m.readdatavalid) begin
          beat_cnt <= beat_nxt;
          if (beat_nxt == burst_reg) begin
            state <= IDLE;
            last_owner <= owner;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_arbiter_2to1.sv
// tb_avalon_arbiter_2to1: directed tests of the 2-to-1 arbiter with two host drivers and a burst RAM model
module tb_avalon_arbiter_2to1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int chk = 0, pass = 0, cyc = 0;
  int t_acc [2];
  int order [$];
  int c0 [$];
  logic [31:0] q0 [$], q1 [$];
  avalon_if #(.ADDR_W(32), .BURSTCOUNT_W(4)) h0 ();
  avalon_if #(.ADDR_W(32), .BURSTCOUNT_W(4)) h1 ();
  avalon_if #(.ADDR_W(32), .BURSTCOUNT_W(4)) m ();
  avalon_arbiter_2to1 #(.BURSTCOUNT_W(4)) dut (.clk(clk), .reset(reset), .h0(h0), .h1(h1), .m(m));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM agent: zero wait states, read beats start the cycle after the command
  logic [31:0] mem [256];
  logic [7:0] rd_addr = 8'h0, wr_addr = 8'h0, wa;
  logic [3:0] rd_left = 4'h0, wr_left = 4'h0, mbc;
  assign mbc = (m.burstcount == 4'h0) ? 4'd1 : m.burstcount;
  assign wa = (wr_left == 4'h0) ? m.address[7:0] : wr_addr;
  assign m.waitrequest = 1'b0;
  always @(posedge clk) begin
    m.readdatavalid <= rd_left != 4'h0;
    m.readdata <= (rd_left != 4'h0) ? mem[rd_addr] : 32'h0;
    if (rd_left != 4'h0) begin
      rd_addr <= rd_addr + 8'h1;
      rd_left <= rd_left - 4'h1;
    end
    if (m.read && !m.waitrequest) begin
      rd_addr <= m.address[7:0];
      rd_left <= mbc;
    end
    if (m.write && !m.waitrequest) begin
      for (int b = 0; b < 4; b++) if (m.byteenable[b]) mem[wa][8*b +: 8] <= m.writedata[8*b +: 8];
      wr_addr <= wa + 8'h1;
      wr_left <= ((wr_left == 4'h0) ? mbc : wr_left) - 4'h1;
    end
  end

  always @(negedge clk) begin
    if (h0.readdatavalid) begin
      q0.push_back(h0.readdata);
      c0.push_back(cyc);
    end
    if (h1.readdatavalid) q1.push_back(h1.readdata);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic drv(input int h, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] bc);
    if (h == 0) begin
      h0.read = rd; h0.write = wr; h0.address = a; h0.writedata = d; h0.byteenable = 4'hF; h0.burstcount = bc;
    end else begin
      h1.read = rd; h1.write = wr; h1.address = a; h1.writedata = d; h1.byteenable = 4'hF; h1.burstcount = bc;
    end
  endtask

  function automatic logic wreq(input int h);
    return (h == 0) ? h0.waitrequest : h1.waitrequest;
  endfunction

  // one whole transaction from host h, entered and left at a falling edge
  task automatic host_xfer(input int h, input logic rd, input logic [31:0] a, input logic [3:0] bc, input logic [31:0] d0, output int ok);
    int k, n;
    ok = 1;
    n = (rd || bc == 4'h0) ? 1 : int'(bc);
    for (int i = 0; i < n; i++) begin
      drv(h, rd, !rd, a, d0 + i, bc);
      #1;
      k = 0;
      while (wreq(h) && k < 200) begin
        @(negedge clk);
        #1;
        k++;
      end
      if (k == 200) ok = 0;
      @(negedge clk);
      t_acc[h] = cyc;
    end
    order.push_back(h);
    drv(h, 1'b0, 1'b0, 32'h0, 32'h0, 4'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drv(0, 1'b0, 1'b1, 32'h10, 32'h1, 4'd1);
    drv(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'd1);
    repeat (3) @(negedge clk);
    chk++; if (h0.waitrequest !== 1'b1) $display("FAIL rst_h0_wait got %b want 1", h0.waitrequest); else pass++;
    chk++; if (h1.waitrequest !== 1'b1) $display("FAIL rst_h1_wait got %b want 1", h1.waitrequest); else pass++;
    chk++; if ({m.read, m.write} !== 2'b00) $display("FAIL rst_m_rdwr got %b want 00", {m.read, m.write}); else pass++;
    chk++; if (m.burstcount !== 4'd1 || m.address !== 32'h0) $display("FAIL rst_m_bus got bc=%0d addr=%h want bc=1 addr=0", m.burstcount, m.address); else pass++;
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd1);
    drv(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk++; if ({h0.waitrequest, h1.waitrequest, m.write, m.read} !== 4'b1100) $display("FAIL idle_nogrant got %b want 1100", {h0.waitrequest, h1.waitrequest, m.write, m.read}); else pass++;
    drv(0, 1'b0, 1'b1, 32'h30, 32'h5A5A5A5A, 4'd1);
    #1;
    chk++; if (h0.waitrequest !== 1'b1) $display("FAIL arb_latency got wait=%b want 1", h0.waitrequest); else pass++;
    @(negedge clk);
    #1;
    chk++; if ({h0.waitrequest, h1.waitrequest, m.write} !== 3'b011 || m.address !== 32'h30) $display("FAIL grant_h0 got wr=%b%b w=%b addr=%h want 011 addr=30", h0.waitrequest, h1.waitrequest, m.write, m.address); else pass++;
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd1);
    @(negedge clk);
  endtask

  task automatic test_single();
    int ok, k;
    q0.delete(); q1.delete();
    host_xfer(0, 1'b0, 32'h10, 4'd1, 32'hDEADBEEF, ok);
    chk++; if (ok != 1) $display("FAIL single_wr_timeout got ok=%0d want 1", ok); else pass++;
    host_xfer(0, 1'b1, 32'h10, 4'd1, 32'h0, ok);
    chk++; if (ok != 1) $display("FAIL single_rd_timeout got ok=%0d want 1", ok); else pass++;
    k = 0;
    while (q0.size() < 1 && k < 20) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    chk++; if (q0.size() != 1) $display("FAIL single_rdv_count got %0d want 1", q0.size()); else pass++;
    chk++; if (q0.size() > 0 && q0[0] !== 32'hDEADBEEF) $display("FAIL single_rdata got %h want deadbeef", q0[0]); else pass++;
    chk++; if (q1.size() != 0) $display("FAIL single_h1_rdv got %0d beats want 0", q1.size()); else pass++;
  endtask

  task automatic test_round_robin();
    int oa, ob, oc, od;
    int exp_order [4];
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    do_reset();
    @(negedge clk);
    order.delete();
    fork
      begin
        host_xfer(0, 1'b0, 32'h40, 4'd1, 32'd100, oa);
        host_xfer(0, 1'b0, 32'h41, 4'd1, 32'd101, ob);
      end
      begin
        host_xfer(1, 1'b0, 32'h42, 4'd1, 32'd200, oc);
        host_xfer(1, 1'b0, 32'h43, 4'd1, 32'd201, od);
      end
    join
    chk++; if ((oa & ob & oc & od) != 1) $display("FAIL rr_timeout got %0d%0d%0d%0d want 1111", oa, ob, oc, od); else pass++;
    chk++; if (order.size() != 4) $display("FAIL rr_count got %0d want 4", order.size()); else pass++;
    for (int i = 0; i < 4; i++) begin
      chk++; if (order.size() > i && order[i] != exp_order[i]) $display("FAIL rr_order[%0d] got h%0d want h%0d", i, order[i], exp_order[i]); else pass++;
    end
  endtask

  task automatic test_burst();
    int o0, o1, k;
    order.delete(); q0.delete(); c0.delete();
    fork
      host_xfer(1, 1'b0, 32'h20, 4'd4, 32'd1, o1);
      begin
        @(negedge clk);
        host_xfer(0, 1'b1, 32'h20, 4'd4, 32'h0, o0);
      end
    join
    chk++; if ((o0 & o1) != 1) $display("FAIL burst_timeout got %0d%0d want 11", o0, o1); else pass++;
    chk++; if (t_acc[0] <= t_acc[1]) $display("FAIL burst_hold got h0_acc=%0d h1_last=%0d want h0 later", t_acc[0], t_acc[1]); else pass++;
    k = 0;
    while (q0.size() < 4 && k < 30) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk++; if (q0.size() != 4) $display("FAIL burst_rdv_count got %0d want 4", q0.size()); else pass++;
    for (int i = 0; i < 4; i++) begin
      chk++; if (q0.size() > i && (q0[i] !== 32'(i + 1) || c0[i] != c0[0] + i)) $display("FAIL burst_beat[%0d] got %h at cyc %0d want %h at cyc %0d", i, q0[i], c0[i], i + 1, c0[0] + i); else pass++;
    end
  endtask

  task automatic test_zero_burst();
    int ok, k;
    q0.delete(); q1.delete();
    host_xfer(1, 1'b0, 32'h50, 4'd0, 32'hCAFE0000, ok);
    chk++; if (ok != 1) $display("FAIL zero_wr_timeout got ok=%0d want 1", ok); else pass++;
    host_xfer(1, 1'b1, 32'h50, 4'd0, 32'h0, ok);
    chk++; if (ok != 1) $display("FAIL zero_rd_timeout got ok=%0d want 1", ok); else pass++;
    k = 0;
    while (q1.size() < 1 && k < 20) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    chk++; if (q1.size() != 1 || q1[0] !== 32'hCAFE0000) $display("FAIL zero_rd got %0d beats first=%h want 1 beat cafe0000", q1.size(), (q1.size() > 0) ? q1[0] : 32'h0); else pass++;
    chk++; if (q0.size() != 0) $display("FAIL zero_h0_rdv got %0d beats want 0", q0.size()); else pass++;
  endtask

  task automatic test_reset_mid_read();
    int ok, k;
    q0.delete();
    host_xfer(0, 1'b1, 32'h20, 4'd4, 32'h0, ok);
    chk++; if (ok != 1) $display("FAIL midrst_rd_timeout got ok=%0d want 1", ok); else pass++;
    k = 0;
    while (q0.size() < 2 && k < 20) begin @(negedge clk); k++; end
    reset = 1'b0;
    @(negedge clk);
    chk++; if ({h0.waitrequest, h0.readdatavalid, m.read} !== 3'b100) $display("FAIL midrst_idle got %b want 100", {h0.waitrequest, h0.readdatavalid, m.read}); else pass++;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk++; if (q0.size() != 2) $display("FAIL midrst_dropped got %0d beats want 2", q0.size()); else pass++;
    chk++; if (q0.size() > 1 && q0[1] !== 32'd2) $display("FAIL midrst_beat2 got %h want 2", q0[1]); else pass++;
  endtask

  initial begin
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd1);
    drv(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd1);
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_zero_burst();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
